// File: rtl/note_seq_simple.sv
// Pattern step sequencer: plays a small note/rest pattern at a programmable tempo.
// It drives the note period address, the note valid strobe and the metronome click.
module note_seq_simple #(
  parameter int nbit_freq_adx = 7,
  parameter int nbit_bar      = 4,
  parameter int nbit_tick     = 20
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     stop,
  input  logic [nbit_tick-1:0]     tempo_thr,
  input  logic [nbit_tick-1:0]     gate_thr,
  input  logic [nbit_bar-1:0]      last_step,
  input  logic                     click_on,
  input  logic                     pat_we,
  input  logic [nbit_bar-1:0]      pat_wadx,
  input  logic [nbit_freq_adx:0]   pat_wdata,
  output logic [nbit_freq_adx-1:0] per_adx_out,
  output logic                     per_adx_valid_out,
  output logic                     click_en_out,
  output logic [nbit_bar-1:0]      step_out,
  output logic                     bar_pulse,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  localparam int DEPTH = 2 ** nbit_bar;

  state_t                          state, state_nxt;
  logic [nbit_tick-1:0]            tick, thr;
  logic [nbit_bar-1:0]             step;
  logic [DEPTH-1:0][nbit_freq_adx:0] mem;
  logic [nbit_freq_adx:0]          note_lat, note_cur;
  logic                            tc, wrap, active, go, in_gate;

  assign thr     = (tempo_thr < nbit_tick'(2)) ? nbit_tick'(2) : tempo_thr;
  // >= rather than == so a tempo drop below the current tick still ends the step
  assign tc      = tick >= (thr - nbit_tick'(1));
  assign wrap    = step >= last_step;
  assign active  = state != IDLE;
  assign go      = (state == IDLE) && start && !stop;
  assign in_gate = tick < gate_thr;
  // tick 0 reads the memory directly; later ticks replay the latched copy
  assign note_cur = (tick == '0) ? mem[step] : note_lat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = PLAY;
      // a stop seen on the terminal tick ends playback at this step boundary
      PLAY:    if (stop) state_nxt = tc ? IDLE : DRAIN;
      DRAIN:   if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick <= '0;
      step <= '0;
    end else if (!active || go) begin
      tick <= '0;
      step <= '0;
    end else if (tc) begin
      tick <= '0;
      step <= (wrap || state_nxt == IDLE) ? '0 : step + nbit_bar'(1);
    end else begin
      tick <= tick + nbit_tick'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        mem <= '0;
    else if (pat_we)  mem[pat_wadx] <= pat_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        note_lat <= '0;
    else if (active && tick == '0)    note_lat <= mem[step];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      per_adx_out       <= '0;
      per_adx_valid_out <= 1'b0;
      click_en_out      <= 1'b0;
      step_out          <= '0;
      bar_pulse         <= 1'b0;
      busy              <= 1'b0;
    end else begin
      per_adx_out       <= active ? note_cur[nbit_freq_adx-1:0] : '0;
      per_adx_valid_out <= active & note_cur[nbit_freq_adx] & in_gate;
      click_en_out      <= active & click_on & (step[1:0] == 2'b00) & in_gate;
      step_out          <= step;
      bar_pulse         <= active & tc & wrap;
      busy              <= active;
    end
  end

endmodule

// File: tb/tb_note_seq_simple.sv
// Directed bench for note_seq_simple: playback, write-during-play, stop, metronome,
// last_step shrink, legato, tempo change and asynchronous reset.
module tb_note_seq_simple;

  logic        clk, rstn, start, stop, click_on, pat_we;
  logic [19:0] tempo_thr, gate_thr;
  logic [3:0]  last_step, pat_wadx, step_out;
  logic [7:0]  pat_wdata;
  logic [6:0]  per_adx_out;
  logic        per_adx_valid_out, click_en_out, bar_pulse, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int k, k2, k3, k4;
  logic [7:0] pat [4];

  note_seq_simple dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .tempo_thr(tempo_thr), .gate_thr(gate_thr), .last_step(last_step),
    .click_on(click_on), .pat_we(pat_we), .pat_wadx(pat_wadx), .pat_wdata(pat_wdata),
    .per_adx_out(per_adx_out), .per_adx_valid_out(per_adx_valid_out),
    .click_en_out(click_en_out), .step_out(step_out), .bar_pulse(bar_pulse), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // advance to 1 time unit after rising edge number e
  task automatic to_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; click_on = 1'b0; pat_we = 1'b0;
    tempo_thr = 20'd8; gate_thr = 20'd5; last_step = 4'd3;
    pat_wadx = '0; pat_wdata = '0;
    pat[0] = 8'h8A; pat[1] = 8'h00; pat[2] = 8'h94; pat[3] = 8'h9E;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", per_adx_valid_out, 0);
    chk("rst_adx", per_adx_out, 0);
    chk("rst_click", click_en_out, 0);
    chk("rst_step", step_out, 0);
    chk("rst_bar", bar_pulse, 0);
    to_edge(2);
    rstn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      pat_we = 1'b1; pat_wadx = 4'(i); pat_wdata = pat[i];
      to_edge(cyc + 1);
    end
    pat_we = 1'b0;
    to_edge(cyc + 1);
    chk("idle_busy", busy, 0);

    // default pattern playback
    start = 1'b1;
    to_edge(cyc + 1);
    k = cyc;
    start = 1'b0;
    chk("k_busy_lag", busy, 0);
    to_edge(k + 1);
    chk("s0_valid", per_adx_valid_out, 1);
    chk("s0_adx", per_adx_out, 10);
    chk("s0_busy", busy, 1);
    chk("s0_step", step_out, 0);
    to_edge(k + 5);  chk("s0_gate_end", per_adx_valid_out, 1);
    to_edge(k + 6);  chk("s0_gate_off", per_adx_valid_out, 0);
    to_edge(k + 9);  chk("s1_rest", per_adx_valid_out, 0);
    chk("s1_step", step_out, 1);
    to_edge(k + 16); chk("s1_rest_end", per_adx_valid_out, 0);
    to_edge(k + 17); chk("s2_valid", per_adx_valid_out, 1);
    chk("s2_adx", per_adx_out, 20);
    chk("s2_step", step_out, 2);
    to_edge(k + 25); chk("s3_adx", per_adx_out, 30);
    chk("s3_step", step_out, 3);
    to_edge(k + 31); chk("bar_pre", bar_pulse, 0);
    to_edge(k + 32); chk("bar_pulse", bar_pulse, 1);
    to_edge(k + 33); chk("bar_post", bar_pulse, 0);
    chk("loop_step", step_out, 0);
    chk("loop_adx", per_adx_out, 10);

    // write to the playing step during its gate
    to_edge(k + 34);
    pat_we = 1'b1; pat_wadx = 4'd0; pat_wdata = 8'h8B;
    to_edge(k + 35);
    pat_we = 1'b0;
    to_edge(k + 36); chk("wr_hold_adx", per_adx_out, 10);
    to_edge(k + 37); chk("wr_hold_adx2", per_adx_out, 10);
    to_edge(k + 65); chk("wr_new_adx", per_adx_out, 11);
    chk("wr_new_valid", per_adx_valid_out, 1);

    // stop at tick 3 of step 2
    to_edge(k + 82); chk("stp_s2_adx", per_adx_out, 20);
    to_edge(k + 83);
    stop = 1'b1;
    to_edge(k + 84);
    stop = 1'b0;
    to_edge(k + 85); chk("stp_gate_full", per_adx_valid_out, 1);
    to_edge(k + 86); chk("stp_gate_off", per_adx_valid_out, 0);
    to_edge(k + 88); chk("stp_busy_tc", busy, 1);
    chk("stp_step_tc", step_out, 2);
    to_edge(k + 89); chk("stp_busy_off", busy, 0);
    chk("stp_step0", step_out, 0);
    chk("stp_valid0", per_adx_valid_out, 0);
    to_edge(k + 97); chk("stp_no_s3", step_out, 0);
    chk("stp_idle", busy, 0);

    // simultaneous start and stop stays idle
    start = 1'b1; stop = 1'b1;
    to_edge(cyc + 3);
    chk("ss_idle", busy, 0);
    stop = 1'b0;
    click_on = 1'b1; last_step = 4'd7;
    to_edge(cyc + 1);
    k2 = cyc;
    start = 1'b0;

    // metronome
    to_edge(k2 + 1);  chk("clk_s0_on", click_en_out, 1);
    to_edge(k2 + 5);  chk("clk_s0_last", click_en_out, 1);
    to_edge(k2 + 6);  chk("clk_s0_off", click_en_out, 0);
    to_edge(k2 + 9);  chk("clk_s1_off", click_en_out, 0);
    to_edge(k2 + 32); chk("clk_s3_off", click_en_out, 0);
    to_edge(k2 + 33); chk("clk_s4_on", click_en_out, 1);
    chk("clk_s4_step", step_out, 4);
    to_edge(k2 + 37); chk("clk_s4_last", click_en_out, 1);
    to_edge(k2 + 38); chk("clk_s4_off", click_en_out, 0);

    // shrink last_step below the playing step, switch to legato gate
    to_edge(k2 + 40);
    last_step = 4'd3; click_on = 1'b0; gate_thr = 20'd20;
    to_edge(k2 + 47); chk("shr_bar_pre", bar_pulse, 0);
    to_edge(k2 + 48); chk("shr_bar", bar_pulse, 1);
    chk("shr_step5", step_out, 5);
    to_edge(k2 + 49); chk("shr_wrap", step_out, 0);
    k3 = k2 + 48;
    to_edge(k3 + 9);  chk("leg_rest", per_adx_valid_out, 0);
    for (int c = 17; c <= 32; c++) begin
      to_edge(k3 + c);
      chk($sformatf("leg_valid_c%0d", c), per_adx_valid_out, 1);
    end
    to_edge(k3 + 25); chk("leg_s3_adx", per_adx_out, 30);

    // tempo drop 8 -> 3 at tick 5 of step 0
    to_edge(k3 + 37);
    tempo_thr = 20'd3;
    to_edge(k3 + 38); chk("tmp_step0", step_out, 0);
    to_edge(k3 + 39); chk("tmp_step1", step_out, 1);
    to_edge(k3 + 42); chk("tmp_step2", step_out, 2);
    to_edge(k3 + 46); chk("tmp_bar_pre", bar_pulse, 0);
    to_edge(k3 + 47); chk("tmp_bar", bar_pulse, 1);

    // tempo below 2 behaves as 2
    tempo_thr = 20'd0;
    to_edge(k3 + 50); chk("t0_step1", step_out, 1);
    to_edge(k3 + 51); chk("t0_step1b", step_out, 1);
    to_edge(k3 + 52); chk("t0_step2", step_out, 2);
    chk("rm_valid_pre", per_adx_valid_out, 1);
    chk("rm_adx_pre", per_adx_out, 20);

    // asynchronous reset mid-note
    #1 rstn = 1'b0;
    #1;
    chk("rm_valid", per_adx_valid_out, 0);
    chk("rm_adx", per_adx_out, 0);
    chk("rm_busy", busy, 0);
    chk("rm_step", step_out, 0);
    to_edge(cyc + 2);
    rstn = 1'b1;
    to_edge(cyc + 10);
    chk("rm_stay_idle", busy, 0);
    chk("rm_stay_valid", per_adx_valid_out, 0);

    // memory was cleared: step 0 now plays a rest
    tempo_thr = 20'd8; gate_thr = 20'd5;
    start = 1'b1;
    to_edge(cyc + 1);
    k4 = cyc;
    start = 1'b0;
    to_edge(k4 + 1);
    chk("clr_busy", busy, 1);
    chk("clr_valid", per_adx_valid_out, 0);
    chk("clr_adx", per_adx_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
